// File: rtl/dmem_arbiter.sv
// Single-port DMEM arbiter between the pipeline and the NIC: the pipeline has priority,
// and a starvation counter forces a one-cycle pipeline stall so the NIC always makes progress.
module dmem_arbiter #(
   parameter int DATA_WIDTH          = 64,
   parameter int DMEM_ADDRESS_LENGTH = 16,
   parameter int STARVE_LIMIT        = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           cpu_mem_en,
   input  logic                           cpu_store_en,
   input  logic [31:0]                    cpu_addr,
   input  logic [DATA_WIDTH-1:0]          cpu_wdata,
   output logic [DATA_WIDTH-1:0]          cpu_rdata,
   output logic                           cpu_stall,
   input  logic                           nic_req,
   input  logic                           nic_we,
   input  logic [DMEM_ADDRESS_LENGTH-1:0] nic_addr,
   input  logic [DATA_WIDTH-1:0]          nic_wdata,
   output logic                           nic_gnt,
   output logic                           nic_rvalid,
   output logic [DATA_WIDTH-1:0]          nic_rdata,
   output logic                           mem_en,
   output logic                           mem_we,
   output logic [DMEM_ADDRESS_LENGTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]          mem_wdata,
   input  logic [DATA_WIDTH-1:0]          mem_rdata
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CPU   = 2'd1;
   localparam logic [1:0] ST_NIC   = 2'd2;
   localparam logic [1:0] ST_FORCE = 2'd3;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic [3:0] starve_cnt;
   logic [3:0] starve_nxt;
   logic [3:0] starve_inc;
   logic       rd_owner_nic;
   logic       grant_cpu;
   logic       grant_nic;

   // Address bits above the decoded DMEM range are intentionally dropped.
   logic unused_addr_bits;
   assign unused_addr_bits = ^cpu_addr[31:DMEM_ADDRESS_LENGTH];

   assign starve_inc = (starve_cnt == 4'd15) ? 4'd15 : starve_cnt + 4'd1;

   always_comb begin
      // NOTE: every signal gets a default first so no path through this block infers a latch.
      grant_cpu  = 1'b0;
      grant_nic  = 1'b0;
      state_nxt  = ST_IDLE;
      starve_nxt = starve_cnt;
      if (state == ST_FORCE) begin
         grant_nic  = nic_req;
         state_nxt  = nic_req ? ST_NIC : ST_IDLE;
         starve_nxt = 4'd0;
      end else if (cpu_mem_en) begin
         grant_cpu = 1'b1;
         state_nxt = ST_CPU;
         if (nic_req) begin
            starve_nxt = starve_inc;
            if (starve_inc == LIMIT) state_nxt = ST_FORCE;
         end
      end else if (nic_req) begin
         grant_nic  = 1'b1;
         state_nxt  = ST_NIC;
         starve_nxt = 4'd0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      if (!rst) begin
         state        <= ST_IDLE;
         starve_cnt   <= 4'd0;
         rd_owner_nic <= 1'b0;
      end else begin
         state        <= state_nxt;
         starve_cnt   <= starve_nxt;
         rd_owner_nic <= grant_nic & ~nic_we;
      end
   end

   // The grant is combinational from inputs, so reset must gate it to keep outputs quiet.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      nic_gnt   = 1'b0;
      if (rst) begin
         if (grant_cpu) begin
            mem_en    = 1'b1;
            mem_we    = cpu_store_en;
            mem_addr  = cpu_addr[DMEM_ADDRESS_LENGTH-1:0];
            mem_wdata = cpu_wdata;
         end else if (grant_nic) begin
            mem_en    = 1'b1;
            mem_we    = nic_we;
            mem_addr  = nic_addr;
            mem_wdata = nic_wdata;
            nic_gnt   = 1'b1;
         end
      end
   end

   assign cpu_stall  = rst & (state == ST_FORCE);
   assign nic_rvalid = rd_owner_nic;
   assign nic_rdata  = rd_owner_nic ? mem_rdata : '0;
   assign cpu_rdata  = rst ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a request-level reference model predicts every cycle's
// outputs, and a negedge monitor pops and compares them against the DUT.
module tb_dmem_arbiter;

   localparam int DW    = 64;
   localparam int AW    = 16;
   localparam int LIMIT = 4;

   logic          clk;
   logic          rst;
   logic          cpu_mem_en;
   logic          cpu_store_en;
   logic [31:0]   cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_stall;
   logic          nic_req;
   logic          nic_we;
   logic [AW-1:0] nic_addr;
   logic [DW-1:0] nic_wdata;
   logic          nic_gnt;
   logic          nic_rvalid;
   logic [DW-1:0] nic_rdata;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   dmem_arbiter #(
      .DATA_WIDTH(DW), .DMEM_ADDRESS_LENGTH(AW), .STARVE_LIMIT(LIMIT)
   ) dut (
      .clk(clk), .rst(rst),
      .cpu_mem_en(cpu_mem_en), .cpu_store_en(cpu_store_en), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .nic_req(nic_req), .nic_we(nic_we), .nic_addr(nic_addr), .nic_wdata(nic_wdata),
      .nic_gnt(nic_gnt), .nic_rvalid(nic_rvalid), .nic_rdata(nic_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   typedef struct {
      logic          mem_en;
      logic          mem_we;
      logic [AW-1:0] mem_addr;
      logic [DW-1:0] mem_wdata;
      logic          nic_gnt;
      logic          cpu_stall;
      logic          nic_rvalid;
      logic [DW-1:0] nic_rdata;
      logic [DW-1:0] cpu_rdata;
   } exp_t;

   exp_t exp_q[$];
   int   n_compared   = 0;
   int   n_mismatched = 0;
   int   cyc          = 0;

   // Reference model: NIC wait count, pending forced grant, pending NIC read, memory image.
   int            m_wait    = 0;
   bit            m_force   = 0;
   bit            m_rd_prev = 0;
   logic [DW-1:0] m_rdata   = '0;
   logic [DW-1:0] m_mem [64];
   bit            last_nic_gnt = 0;
   bit            last_stall   = 0;

   // DMEM emulation (environment), one-cycle read latency.
   logic [DW-1:0] dmem [64];
   bit            loaded = 0;

   function automatic logic [DW-1:0] init_word(int i);
      if (i == 16) return 64'hDEAD_BEEF;
      return {32'(i) * 32'h9E37_79B9, 32'hC0DE_0000 | 32'(i)};
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < 64; i++) dmem[i] <= init_word(i);
         mem_rdata <= '0;
         loaded    <= 1'b1;
      end else if (mem_en) begin
         if (mem_we) dmem[mem_addr[5:0]] <= mem_wdata;
         else        mem_rdata <= dmem[mem_addr[5:0]];
      end
   end

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("FAIL %s (t=%0t): got %h, expected %h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("mem_en",     DW'(mem_en),     DW'(e.mem_en));
         check("mem_we",     DW'(mem_we),     DW'(e.mem_we));
         check("mem_addr",   DW'(mem_addr),   DW'(e.mem_addr));
         check("mem_wdata",  mem_wdata,       e.mem_wdata);
         check("nic_gnt",    DW'(nic_gnt),    DW'(e.nic_gnt));
         check("cpu_stall",  DW'(cpu_stall),  DW'(e.cpu_stall));
         check("nic_rvalid", DW'(nic_rvalid), DW'(e.nic_rvalid));
         check("nic_rdata",  nic_rdata,       e.nic_rdata);
         check("cpu_rdata",  cpu_rdata,       e.cpu_rdata);
      end
   end

   // One cycle of stimulus; the model predicts the outputs and queues them for the monitor.
   task automatic drive(input bit r, input bit ce, input bit cs, input logic [31:0] ca,
                        input logic [DW-1:0] cw, input bit nr, input bit nw,
                        input logic [AW-1:0] na, input logic [DW-1:0] nd);
      exp_t e;
      bit   g_cpu, g_nic, stall;
      @(posedge clk);
      #1;
      rst = r; cpu_mem_en = ce; cpu_store_en = cs; cpu_addr = ca; cpu_wdata = cw;
      nic_req = nr; nic_we = nw; nic_addr = na; nic_wdata = nd;
      e = '{default: '0};
      g_cpu = 0; g_nic = 0; stall = 0;
      if (!r) begin
         m_wait = 0; m_force = 0; m_rd_prev = 0;
      end else begin
         stall = m_force;
         if (m_force) begin
            g_nic = nr; m_force = 0; m_wait = 0;
         end else if (ce) begin
            g_cpu = 1;
            if (nr) begin
               if (m_wait < 15) m_wait++;
               if (m_wait == LIMIT) m_force = 1;
            end
         end else if (nr) begin
            g_nic = 1; m_wait = 0;
         end
         e.cpu_stall  = stall;
         e.nic_gnt    = g_nic;
         e.mem_en     = g_cpu | g_nic;
         e.mem_we     = g_cpu ? cs : (g_nic & nw);
         e.mem_addr   = g_cpu ? ca[AW-1:0] : (g_nic ? na : '0);
         e.mem_wdata  = g_cpu ? cw : (g_nic ? nd : '0);
         e.nic_rvalid = m_rd_prev;
         e.nic_rdata  = m_rd_prev ? m_rdata : '0;
         e.cpu_rdata  = m_rdata;
         if (g_cpu) begin
            if (cs) m_mem[ca[5:0]] = cw;
            else    m_rdata = m_mem[ca[5:0]];
         end else if (g_nic) begin
            if (nw) m_mem[na[5:0]] = nd;
            else    m_rdata = m_mem[na[5:0]];
         end
         m_rd_prev = g_nic & ~nw;
      end
      exp_q.push_back(e);
      last_nic_gnt = g_nic;
      last_stall   = stall;
      cyc++;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got %0d cycles, expected under 3000", cyc);
      $fatal(1, "watchdog");
   end

   bit            s_ce, s_cs, s_nr, s_nw, s_r;
   logic [31:0]   s_ca;
   logic [DW-1:0] s_cw, s_nd;
   logic [AW-1:0] s_na;

   initial begin
      for (int i = 0; i < 64; i++) m_mem[i] = init_word(i);
      rst = 1'b0; cpu_mem_en = 0; cpu_store_en = 0; cpu_addr = '0; cpu_wdata = '0;
      nic_req = 0; nic_we = 0; nic_addr = '0; nic_wdata = '0;

      // Reset held with both sides requesting, then release: pipeline first, starvation forces the NIC.
      repeat (3) drive(0, 1, 0, 32'hABCD_0008, 64'h11, 1, 0, 16'h0020, 64'h0);
      repeat (6) drive(1, 1, 0, 32'hABCD_0008, 64'h11, 1, 0, 16'h0020, 64'h0);
      drive(1, 0, 0, 32'h0, 64'h0, 1, 0, 16'h0021, 64'h0);
      drive(1, 0, 0, 32'h0, 64'h0, 0, 0, 16'h0, 64'h0);

      // NIC-only read returning 0xDEADBEEF one cycle later.
      drive(1, 0, 0, 32'h0, 64'h0, 1, 0, 16'h0010, 64'h0);
      drive(1, 0, 0, 32'h0, 64'h0, 0, 0, 16'h0, 64'h0);

      // Interleave: pipeline toggles, NIC request held.
      drive(1, 1, 0, 32'h0000_0003, 64'h0, 1, 0, 16'h0005, 64'h0);
      drive(1, 0, 0, 32'h0,         64'h0, 1, 0, 16'h0005, 64'h0);
      drive(1, 1, 1, 32'h0000_0007, 64'h77, 1, 0, 16'h0006, 64'h0);
      drive(1, 0, 0, 32'h0,         64'h0, 1, 0, 16'h0006, 64'h0);

      // NIC write then immediate read of the same address.
      drive(1, 0, 0, 32'h0, 64'h0, 1, 1, 16'h0004, 64'h1234);
      drive(1, 0, 0, 32'h0, 64'h0, 1, 0, 16'h0004, 64'h0);
      drive(1, 0, 0, 32'h0, 64'h0, 0, 0, 16'h0, 64'h0);

      // Reset asserted in the forced-grant cycle, then contention after release.
      repeat (4) drive(1, 1, 0, 32'h0000_0009, 64'h0, 1, 0, 16'h000A, 64'h0);
      drive(0, 1, 0, 32'h0000_0009, 64'h0, 1, 0, 16'h000A, 64'h0);
      drive(1, 1, 0, 32'h0000_0009, 64'h0, 1, 0, 16'h000A, 64'h0);
      drive(1, 0, 0, 32'h0,         64'h0, 1, 0, 16'h000A, 64'h0);

      // Randomized traffic obeying the NIC hold rule and the pipeline re-present rule.
      s_nr = 0;
      for (int i = 0; i < 2000; i++) begin
         if (!last_stall) begin
            s_ce = ($urandom_range(0, 9) < 6);
            s_cs = $urandom_range(0, 1) == 1;
            s_ca = {16'($urandom), 10'd0, 6'($urandom)};
            s_cw = {$urandom, $urandom};
         end
         if (last_nic_gnt || !s_nr) begin
            s_nr = $urandom_range(0, 1) == 1;
            s_nw = $urandom_range(0, 1) == 1;
            s_na = {10'd0, 6'($urandom)};
            s_nd = {$urandom, $urandom};
         end
         s_r = ($urandom_range(0, 199) != 0);
         drive(s_r, s_ce, s_cs, s_ca, s_cw, s_nr, s_nw, s_na, s_nd);
      end

      repeat (2) @(negedge clk);
      check("scoreboard_drain", DW'(exp_q.size()), '0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port data-memory arbiter that shares the 64-bit DMEM between the 4-stage processor pipeline and an external network-interface (NIC) requester. The pipeline normally has priority. A starvation counter forces a one-cycle pipeline stall so the NIC is guaranteed progress. The block sits between the pipeline's dmem_* ports, the NIC port and the DMEM macro, and tracks read ownership so returned data reaches the correct requester.

## Interface
- DATA_WIDTH, 64, memory word width
- DMEM_ADDRESS_LENGTH, 16, DMEM address bits actually decoded
- STARVE_LIMIT, 4, consecutive denied NIC cycles before a forced grant (legal range 1..15)
- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-low reset
- cpu_mem_en  input  1  pipeline DMEM access request this cycle
- cpu_store_en  input  1  pipeline access is a write
- cpu_addr  input  32  pipeline address; only low DMEM_ADDRESS_LENGTH bits are used
- cpu_wdata  input  DATA_WIDTH  pipeline write data
- cpu_rdata  output  DATA_WIDTH  read data returned to the pipeline
- cpu_stall  output  1  pipeline must hold its stage-2 instruction this cycle
- nic_req  input  1  NIC access request
- nic_we  input  1  NIC access is a write
- nic_addr  input  DMEM_ADDRESS_LENGTH  NIC address
- nic_wdata  input  DATA_WIDTH  NIC write data
- nic_gnt  output  1  NIC access accepted this cycle
- nic_rvalid  output  1  nic_rdata is valid this cycle
- nic_rdata  output  DATA_WIDTH  read data returned to the NIC
- mem_en, mem_we  output  1  DMEM enable and write strobe
- mem_addr  output  DMEM_ADDRESS_LENGTH  DMEM address
- mem_wdata  output  DATA_WIDTH  DMEM write data
- mem_rdata  input  DATA_WIDTH  DMEM read data, valid one cycle after the read is issued

## Operation
- State register with states IDLE, CPU, NIC and FORCE. IDLE, CPU and NIC record the owner of the previous cycle. FORCE means the NIC is granted this cycle with the pipeline stalled.
- starve_cnt: 4-bit register counting consecutive cycles with nic_req=1 and nic_gnt=0.
- Per-cycle grant decision, combinational from the current state and inputs:
  - FORCE and nic_req=1: grant the NIC; cpu_stall=1; the pipeline request is ignored. Next state NIC; starve_cnt←0.
  - FORCE and nic_req=0 (protocol violation): no access; cpu_stall=1. Next state IDLE; starve_cnt←0.
  - Otherwise, cpu_mem_en=1: grant the pipeline. If nic_req=1, starve_cnt←starve_cnt+1. If the incremented value equals STARVE_LIMIT, next state FORCE; otherwise next state CPU.
  - Otherwise, nic_req=1: grant the NIC. Next state NIC; starve_cnt←0.
  - Otherwise: no access. Next state IDLE; starve_cnt holds.
- mem_en, mem_we, mem_addr and mem_wdata are muxed from the granted requester and are all 0 when nothing is granted.
- nic_gnt=1 only in a cycle where the NIC is granted.
- NIC handshake: nic_req, nic_we, nic_addr and nic_wdata must stay stable until the cycle in which nic_gnt=1. In that cycle the transfer completes. nic_req may drop or present a new request in the next cycle.
- rd_owner_nic register: set when the NIC is granted with nic_we=0, cleared otherwise.
- nic_rvalid = rd_owner_nic.
- nic_rdata = mem_rdata when nic_rvalid=1, otherwise 0.
- cpu_rdata = mem_rdata unconditionally; the pipeline selects it with its own load flag.
- Pipeline contract: in a cpu_stall cycle the pipeline does not advance stage 2, and it re-presents the same request in the next cycle.
- STARVE_LIMIT is an elaboration constant and is only compared; no arithmetic wraps. starve_cnt saturates at 15.

## Timing
- Reset: while rst=0, all outputs are 0 regardless of inputs. The state is IDLE, starve_cnt=0 and rd_owner_nic=0.
- Reset asserted mid-operation aborts any pending grant and suppresses nic_rvalid for an in-flight read.
- After rst deasserts, arbitration starts on the first rising edge.
- Grant latency: 0 cycles. A request and its grant appear in the same cycle.
- Read data latency: 1 cycle. nic_rvalid rises exactly one cycle after a NIC read grant.
- Worst-case NIC wait: STARVE_LIMIT cycles of denial, then a grant in the following cycle.
- cpu_stall lasts exactly one cycle per FORCE entry.
- Back-to-back FORCE is impossible, because FORCE is always followed by NIC or IDLE.
- Simultaneous new requests from both sides with state not FORCE: the pipeline wins.
- A NIC write followed immediately by a NIC read to the same address returns the new data. Ordering is provided by DMEM.

## Test plan
- Reset: hold rst=0 with cpu_mem_en=1 and nic_req=1 -> mem_en=0, nic_gnt=0, cpu_stall=0, nic_rvalid=0. Release rst -> the first cycle grants the pipeline.
- NIC only: nic_req=1, nic_we=0, nic_addr=0x0010, mem_rdata=0xDEAD_BEEF next cycle -> nic_gnt=1 and mem_addr=0x0010 in cycle 0; nic_rvalid=1 and nic_rdata=0xDEADBEEF in cycle 1.
- Starvation with STARVE_LIMIT=4: cpu_mem_en=1 and nic_req=1 continuously -> pipeline granted in cycles 0–3; cycle 4 has cpu_stall=1, nic_gnt=1 and mem_addr=nic_addr; cycle 5 grants the pipeline again with starve_cnt=0.
- Interleave: cpu_mem_en toggles 1,0,1,0 with nic_req=1 held -> nic_gnt=1 in cycle 1; cpu_stall never asserts.
- NIC write then read: nic_we=1, addr 0x0004, wdata 0x1234, then a read of 0x0004 -> mem_we=1 with mem_wdata=0x1234; nic_rvalid=0 after the write; the read returns 0x1234.
- Reset during FORCE: assert rst=0 in the cpu_stall cycle -> all outputs 0 immediately. After release the state is IDLE and the pipeline wins the next contention.
